sound_arbiter: RTL and testbench
================================

SOUND_ARBITER -- requirements
Module: sound_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of sound-effect requesters (index 0 = highest priority).
REQ-002 Parameter AMPLITUDE, default 32'd100000000, square-wave magnitude written to both channels.
REQ-003 CLOCK_50  input  1  sole clock; all state changes on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 mute  input  1  level; silences output and aborts playback (game-over).
REQ-006 req  input  NUM_REQ  level request per sound effect; held until matching ack.
REQ-007 req_half_period  input  NUM_REQ*32  per-requester tone half-period in clock cycles; 0 = silence.
REQ-008 req_duration  input  NUM_REQ*32  per-requester effect length in clock cycles.
REQ-009 music_valid  input  1  background melody present.
REQ-010 music_half_period  input  32  melody half-period in cycles; 0 = rest.
REQ-011 audio_out_allowed  input  1  audio controller output FIFO has space.
REQ-012 write_audio_out  output  1  sample write strobe to audio controller.
REQ-013 left_channel_audio_out  output  32  signed sample, left.
REQ-014 right_channel_audio_out  output  32  signed sample, right; always equals left.
REQ-015 ack  output  NUM_REQ  one-cycle pulse when an effect finishes or is aborted.
REQ-016 grant_id  output  clog2(NUM_REQ)  index of effect playing; valid only while busy.
REQ-017 busy  output  1  high in state SFX.

Function
REQ-018 FSM states SHALL be IDLE, MUSIC, SFX.
REQ-019 IDLE -> SFX when any req is high and mute low; IDLE -> MUSIC when no req, music_valid high, mute low.
REQ-020 MUSIC -> SFX when any req is high; MUSIC -> IDLE when music_valid falls.
REQ-021 Grant SHALL go to the lowest-index active req, with grant_id and the requester's half-period and duration latched in the transition cycle.
REQ-022 SFX lasts exactly max(req_duration,1) cycles, counted from the first cycle in SFX; in the last cycle ack[grant_id] pulses for one cycle, next state MUSIC if music_valid else IDLE.
REQ-023 req[i] SHALL NOT be re-granted in the cycle ack[i] is high; it is eligible from the following cycle.
REQ-024 Tone generator: on every state entry, phase counter = 0 and sign = 0; sign toggles when the counter reaches H-1, and the counter then wraps to 0.
REQ-025 In MUSIC, a changed music_half_period SHALL be adopted only at a toggle boundary (no truncated half-cycles).
REQ-026 Sample SHALL be +AMPLITUDE when sign = 0, and -AMPLITUDE (two's complement) when sign = 1; 0 in IDLE, when H = 0, or while mute is high.
REQ-027 Samples SHALL be registered; write_audio_out = audio_out_allowed every cycle, including zero samples.
REQ-028 mute high SHALL force the next state to IDLE; if in SFX, ack[grant_id] pulses in that cycle. No grant is made while mute is high.
REQ-029 Simultaneous req rise and music_valid: SFX wins.

Reset
REQ-030 reset_n low SHALL asynchronously set state IDLE, counters 0, sign 0, samples 0, ack 0, grant_id 0, busy 0; write_audio_out still follows audio_out_allowed.
REQ-031 Reset asserted mid-effect SHALL NOT produce an ack.

Configuration
REQ-032 Macro SOUND_ARB_PREEMPT_EN defined: in SFX, a req with index lower than grant_id aborts the current effect (ack for it pulses) and is granted in the same cycle, and the tone restarts per REQ-024.
REQ-033 Macro SOUND_ARB_PREEMPT_EN undefined: an effect always plays to completion; requests wait.

Structure
REQ-034 Package sound_pkg SHALL hold the state enum, AMPLITUDE default, and the default NUM_REQ.
REQ-035 Sub-module square_gen SHALL hold the phase counter, sign register, and half-period boundary latch; the arbiter FSM drives its restart and half-period inputs.

Verification
REQ-036 req = 4'b0001, half 4, duration 20, music off -> sign toggles every 4 cycles starting with +AMPLITUDE; ack[0] pulses in cycle 20; returns to IDLE with sample 0.
REQ-037 req[2] and req[1] rise together -> grant_id = 1 first; req[2] is granted the cycle after ack[1].
REQ-038 MUSIC with half 100; half changed to 50 mid-phase -> current half-cycle completes at 100, then toggles every 50.
REQ-039 mute raised during SFX at cycle 7 -> ack pulses in that cycle, next state IDLE, samples 0, no grants while mute is high.
REQ-040 With SOUND_ARB_PREEMPT_EN: req[3] playing, req[0] rises -> ack[3] pulses, grant_id = 0, phase restarts; without the macro, req[0] waits for ack[3].
REQ-041 reset_n low during SFX -> all outputs at reset values asynchronously, no ack; audio_out_allowed toggling is mirrored on write_audio_out throughout.

Source files
------------

// File: rtl/sound_pkg.sv
// Shared definitions for the sound-effect arbiter: FSM states, default sizing
// and the two's-complement helper used to build the negative half of the wave.
package sound_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MUSIC = 2'd1,
    SFX   = 2'd2
  } state_e;

  localparam int unsigned DEFAULT_NUM_REQ   = 4;
  localparam logic [31:0] DEFAULT_AMPLITUDE = 32'd100000000;

  function automatic logic [31:0] negate(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

endpackage

// File: rtl/square_gen.sv
// Square-wave phase generator: phase counter, sign register and the latched
// half-period that is only replaced at a toggle boundary.
module square_gen (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        restart_i,
  input  logic [31:0] halfPeriod_i,
  output logic        sign_o,
  output logic [31:0] half_o
);

  logic [31:0] cnt_q, cnt_d;
  logic [31:0] half_q, half_d;
  logic        sign_q, sign_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      half_q <= '0;
      sign_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      half_q <= half_d;
      sign_q <= sign_d;
    end
  end

  // A new half-period is only taken on restart, at a toggle, or while resting,
  // so a half-cycle already in progress is never cut short.
  always_comb begin
    cnt_d  = cnt_q + 32'd1;
    sign_d = sign_q;
    half_d = half_q;
    if (restart_i || (half_q == '0)) begin
      cnt_d  = '0;
      sign_d = 1'b0;
      half_d = halfPeriod_i;
    end else if (cnt_q == (half_q - 32'd1)) begin
      cnt_d  = '0;
      sign_d = ~sign_q;
      half_d = halfPeriod_i;
    end
  end

  assign sign_o = sign_q;
  assign half_o = half_q;

endmodule

// File: rtl/sound_arbiter.sv
// Arbitrates prioritised sound effects over background music and drives a
// square wave to the audio controller. Define SOUND_ARB_PREEMPT_EN to let a
// higher-priority request abort the effect currently playing.
module sound_arbiter
  import sound_pkg::*;
#(
  parameter int          NUM_REQ   = DEFAULT_NUM_REQ,
  parameter logic [31:0] AMPLITUDE = DEFAULT_AMPLITUDE,
  localparam int         GW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                   CLOCK_50,
  input  logic                   reset_n,
  input  logic                   mute,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ*32-1:0]  req_half_period,
  input  logic [NUM_REQ*32-1:0]  req_duration,
  input  logic                   music_valid,
  input  logic [31:0]            music_half_period,
  input  logic                   audio_out_allowed,
  output logic                   write_audio_out,
  output logic [31:0]            left_channel_audio_out,
  output logic [31:0]            right_channel_audio_out,
  output logic [NUM_REQ-1:0]     ack,
  output logic [GW-1:0]          grant_id,
  output logic                   busy
);

  state_e      state_q, state_d;
  logic [GW-1:0] grantId_q, grantId_d;
  logic [31:0] sfxHalf_q, sfxHalf_d;
  logic [31:0] durLast_q, durLast_d;
  logic [31:0] durCnt_q, durCnt_d;
  logic [31:0] sample_q, sample_d;

  logic [31:0]   reqHalf [NUM_REQ];
  logic [31:0]   reqDur  [NUM_REQ];
  logic [GW-1:0] winner;
  logic          anyReq, doGrant, preempt, finish, restart;
  logic [31:0]   toneHalfSel, toneHalf, grantDur;
  logic          toneSign;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign reqHalf[g] = req_half_period[g*32 +: 32];
    assign reqDur[g]  = req_duration[g*32 +: 32];
  end

  // Lowest active index wins.
  always_comb begin
    winner = '0;
    anyReq = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        winner = GW'(i);
        anyReq = 1'b1;
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      grantId_q <= '0;
      sfxHalf_q <= '0;
      durLast_q <= '0;
      durCnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      grantId_q <= grantId_d;
      sfxHalf_q <= sfxHalf_d;
      durLast_q <= durLast_d;
      durCnt_q  <= durCnt_d;
    end
  end

  // A zero duration still plays for one cycle, hence durLast saturates at 0.
  always_comb begin
    state_d   = state_q;
    grantId_d = grantId_q;
    sfxHalf_d = sfxHalf_q;
    durLast_d = durLast_q;
    durCnt_d  = durCnt_q;
    doGrant   = 1'b0;
    preempt   = 1'b0;
    finish    = 1'b0;
    grantDur  = reqDur[winner];
    unique case (state_q)
      IDLE: begin
        if (!mute) begin
          if (anyReq)           doGrant = 1'b1;
          else if (music_valid) state_d = MUSIC;
        end
      end
      MUSIC: begin
        if (mute)              state_d = IDLE;
        else if (anyReq)       doGrant = 1'b1;
        else if (!music_valid) state_d = IDLE;
      end
      SFX: begin
        durCnt_d = durCnt_q + 32'd1;
        if (mute) begin
          finish  = 1'b1;
          state_d = IDLE;
        end
`ifdef SOUND_ARB_PREEMPT_EN
        else if (anyReq && (winner < grantId_q)) begin
          finish  = 1'b1;
          preempt = 1'b1;
          doGrant = 1'b1;
        end
`endif
        else if (durCnt_q == durLast_q) begin
          finish  = 1'b1;
          state_d = music_valid ? MUSIC : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (doGrant) begin
      state_d   = SFX;
      grantId_d = winner;
      sfxHalf_d = reqHalf[winner];
      durLast_d = (grantDur == '0) ? '0 : grantDur - 32'd1;
      durCnt_d  = '0;
    end
  end

  always_comb begin
    ack = '0;
    if (finish) ack[grantId_q] = 1'b1;
    busy = (state_q == SFX);
  end

  assign toneHalfSel = (state_d == SFX) ? sfxHalf_d : music_half_period;
  assign restart     = (state_d != state_q) || preempt;

  square_gen u_tone (
    .clk_i        (CLOCK_50),
    .rst_ni       (reset_n),
    .restart_i    (restart),
    .halfPeriod_i (toneHalfSel),
    .sign_o       (toneSign),
    .half_o       (toneHalf)
  );

  always_comb begin
    sample_d = '0;
    if ((state_q != IDLE) && !mute && (toneHalf != '0))
      sample_d = toneSign ? negate(AMPLITUDE) : AMPLITUDE;
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) sample_q <= '0;
    else          sample_q <= sample_d;
  end

  assign write_audio_out         = audio_out_allowed;
  assign left_channel_audio_out  = sample_q;
  assign right_channel_audio_out = sample_q;
  assign grant_id                = grantId_q;

endmodule

// File: tb/tb_sound_arbiter.sv
// Scoreboard bench for sound_arbiter: directed scenarios push hand-computed
// ack events and per-cycle sample expectations; a negedge monitor pops them.
module tb_sound_arbiter;

  localparam logic [31:0] POS  = 32'd100000000;
  localparam logic [31:0] NEG  = ~POS + 32'd1;
  localparam logic [31:0] ZERO = 32'd0;

  typedef struct {
    int          cycle;
    logic [3:0]  ackVec;
    logic [1:0]  gid;
  } ackExp_t;

  typedef struct {
    int          cycle;
    logic [31:0] sample;
    logic        busy;
    logic [1:0]  gid;
  } sampleExp_t;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         mute;
  logic [3:0]   req;
  logic [127:0] req_half_period;
  logic [127:0] req_duration;
  logic         music_valid;
  logic [31:0]  music_half_period;
  logic         audio_out_allowed;
  logic         write_audio_out;
  logic [31:0]  left_channel_audio_out;
  logic [31:0]  right_channel_audio_out;
  logic [3:0]   ack;
  logic [1:0]   grant_id;
  logic         busy;

  int assertCount = 0;
  int failCount   = 0;
  int cyc         = 0;
  int c0;

  ackExp_t    ackQ[$];
  sampleExp_t sampleQ[$];
  ackExp_t    aExp;
  sampleExp_t sExp;

  sound_arbiter dut (
    .CLOCK_50                (clk),
    .reset_n                 (reset_n),
    .mute                    (mute),
    .req                     (req),
    .req_half_period         (req_half_period),
    .req_duration            (req_duration),
    .music_valid             (music_valid),
    .music_half_period       (music_half_period),
    .audio_out_allowed       (audio_out_allowed),
    .write_audio_out         (write_audio_out),
    .left_channel_audio_out  (left_channel_audio_out),
    .right_channel_audio_out (right_channel_audio_out),
    .ack                     (ack),
    .grant_id                (grant_id),
    .busy                    (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic goTo(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input int atCycle, input logic [3:0] r);
    goTo(atCycle);
    req = r;
  endtask

  task automatic setEffect(input int idx, input logic [31:0] h, input logic [31:0] d);
    req_half_period[idx*32 +: 32] = h;
    req_duration[idx*32 +: 32]    = d;
  endtask

  task automatic expectAck(input int c, input logic [3:0] a, input logic [1:0] g);
    ackQ.push_back('{cycle: c, ackVec: a, gid: g});
  endtask

  task automatic expectSample(input int c, input logic [31:0] s, input logic b, input logic [1:0] g);
    sampleQ.push_back('{cycle: c, sample: s, busy: b, gid: g});
  endtask

  // Monitor: strobe mirroring every cycle, ack events and scheduled samples.
  always @(negedge clk) begin
    checkOutput("write_strobe", 32'(write_audio_out), 32'(audio_out_allowed));
    if (ack != 4'b0) begin
      if (ackQ.size() == 0) begin
        checkOutput("ack_unexpected", {28'b0, ack}, ZERO);
      end else begin
        aExp = ackQ.pop_front();
        checkOutput("ack_vector", {28'b0, ack}, {28'b0, aExp.ackVec});
        checkOutput("ack_cycle", 32'(cyc), 32'(aExp.cycle));
        checkOutput("ack_grant_id", {30'b0, grant_id}, {30'b0, aExp.gid});
      end
    end
    while (sampleQ.size() > 0 && sampleQ[0].cycle < cyc) begin
      sExp = sampleQ.pop_front();
      checkOutput("sample_missed_cycle", 32'(cyc), 32'(sExp.cycle));
    end
    if (sampleQ.size() > 0 && sampleQ[0].cycle == cyc && write_audio_out) begin
      sExp = sampleQ.pop_front();
      checkOutput("sample_left", left_channel_audio_out, sExp.sample);
      checkOutput("sample_right", right_channel_audio_out, sExp.sample);
      checkOutput("busy", 32'(busy), 32'(sExp.busy));
      if (sExp.busy) checkOutput("grant_id", {30'b0, grant_id}, {30'b0, sExp.gid});
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_n           = 1'b0;
    mute              = 1'b0;
    req               = 4'b0;
    req_half_period   = '0;
    req_duration      = '0;
    music_valid       = 1'b0;
    music_half_period = '0;
    audio_out_allowed = 1'b1;

    // Reset state, with the strobe still following audio_out_allowed.
    goTo(2);
    audio_out_allowed = 1'b0;
    #2;
    checkOutput("reset_busy", 32'(busy), ZERO);
    checkOutput("reset_ack", {28'b0, ack}, ZERO);
    checkOutput("reset_grant_id", {30'b0, grant_id}, ZERO);
    checkOutput("reset_left", left_channel_audio_out, ZERO);
    checkOutput("reset_strobe", 32'(write_audio_out), ZERO);
    goTo(3);
    audio_out_allowed = 1'b1;
    goTo(5);
    reset_n = 1'b1;

    // Single effect: half 4, duration 20, back to IDLE.
    goTo(8); c0 = cyc;
    setEffect(0, 32'd4, 32'd20);
    applyStimulus(c0, 4'b0001);
    expectAck(c0 + 20, 4'b0001, 2'd0);
    expectSample(c0 + 1,  ZERO, 1'b1, 2'd0);
    expectSample(c0 + 2,  POS,  1'b1, 2'd0);
    expectSample(c0 + 5,  POS,  1'b1, 2'd0);
    expectSample(c0 + 6,  NEG,  1'b1, 2'd0);
    expectSample(c0 + 9,  NEG,  1'b1, 2'd0);
    expectSample(c0 + 10, POS,  1'b1, 2'd0);
    expectSample(c0 + 21, POS,  1'b0, 2'd0);
    expectSample(c0 + 22, ZERO, 1'b0, 2'd0);
    applyStimulus(c0 + 21, 4'b0000);

    // Simultaneous req[2]/req[1]: 1 first, 2 granted right after ack[1].
    goTo(c0 + 25); c0 = cyc;
    setEffect(1, 32'd3, 32'd5);
    setEffect(2, 32'd2, 32'd3);
    applyStimulus(c0, 4'b0110);
    expectAck(c0 + 5, 4'b0010, 2'd1);
    expectAck(c0 + 9, 4'b0100, 2'd2);
    expectSample(c0 + 2,  POS,  1'b1, 2'd1);
    expectSample(c0 + 5,  NEG,  1'b1, 2'd1);
    expectSample(c0 + 7,  ZERO, 1'b1, 2'd2);
    expectSample(c0 + 8,  POS,  1'b1, 2'd2);
    expectSample(c0 + 10, NEG,  1'b0, 2'd0);
    expectSample(c0 + 11, ZERO, 1'b0, 2'd0);
    applyStimulus(c0 + 6, 4'b0100);
    applyStimulus(c0 + 10, 4'b0000);

    // Music half-period change is adopted only at the next toggle.
    goTo(c0 + 14); c0 = cyc;
    music_valid = 1'b1;
    music_half_period = 32'd100;
    expectSample(c0 + 2,   POS,  1'b0, 2'd0);
    expectSample(c0 + 101, POS,  1'b0, 2'd0);
    expectSample(c0 + 102, NEG,  1'b0, 2'd0);
    expectSample(c0 + 151, NEG,  1'b0, 2'd0);
    expectSample(c0 + 152, POS,  1'b0, 2'd0);
    expectSample(c0 + 201, POS,  1'b0, 2'd0);
    expectSample(c0 + 202, NEG,  1'b0, 2'd0);
    expectSample(c0 + 207, ZERO, 1'b0, 2'd0);
    goTo(c0 + 30);
    music_half_period = 32'd50;
    goTo(c0 + 205);
    music_valid = 1'b0;

    // Mute at SFX cycle 7, then no grant while muted.
    goTo(c0 + 210); c0 = cyc;
    setEffect(0, 32'd4, 32'd20);
    setEffect(2, 32'd5, 32'd2);
    applyStimulus(c0, 4'b0001);
    expectAck(c0 + 7, 4'b0001, 2'd0);
    expectAck(c0 + 17, 4'b0100, 2'd2);
    expectSample(c0 + 6,  NEG,  1'b1, 2'd0);
    expectSample(c0 + 8,  ZERO, 1'b0, 2'd0);
    expectSample(c0 + 12, ZERO, 1'b0, 2'd0);
    expectSample(c0 + 16, ZERO, 1'b1, 2'd2);
    expectSample(c0 + 17, POS,  1'b1, 2'd2);
    expectSample(c0 + 18, POS,  1'b0, 2'd0);
    expectSample(c0 + 19, ZERO, 1'b0, 2'd0);
    goTo(c0 + 7);
    mute = 1'b1;
    applyStimulus(c0 + 8, 4'b0100);
    goTo(c0 + 15);
    mute = 1'b0;
    applyStimulus(c0 + 18, 4'b0000);

    // req[0] arrives while req[3] plays.
    goTo(c0 + 22); c0 = cyc;
    setEffect(3, 32'd6, 32'd10);
    setEffect(0, 32'd2, 32'd3);
    applyStimulus(c0, 4'b1000);
`ifdef SOUND_ARB_PREEMPT_EN
    expectAck(c0 + 4, 4'b1000, 2'd3);
    expectAck(c0 + 7, 4'b0001, 2'd0);
    expectSample(c0 + 5, POS,  1'b1, 2'd0);
    expectSample(c0 + 6, POS,  1'b1, 2'd0);
    expectSample(c0 + 7, POS,  1'b1, 2'd0);
    expectSample(c0 + 8, NEG,  1'b0, 2'd0);
    expectSample(c0 + 9, ZERO, 1'b0, 2'd0);
    applyStimulus(c0 + 4, 4'b1001);
    applyStimulus(c0 + 5, 4'b0001);
    applyStimulus(c0 + 8, 4'b0000);
`else
    expectAck(c0 + 10, 4'b1000, 2'd3);
    expectAck(c0 + 14, 4'b0001, 2'd0);
    expectSample(c0 + 7,  POS,  1'b1, 2'd3);
    expectSample(c0 + 8,  NEG,  1'b1, 2'd3);
    expectSample(c0 + 11, NEG,  1'b0, 2'd0);
    expectSample(c0 + 12, ZERO, 1'b1, 2'd0);
    expectSample(c0 + 13, POS,  1'b1, 2'd0);
    expectSample(c0 + 15, NEG,  1'b0, 2'd0);
    expectSample(c0 + 16, ZERO, 1'b0, 2'd0);
    applyStimulus(c0 + 4, 4'b1001);
    applyStimulus(c0 + 11, 4'b0001);
    applyStimulus(c0 + 15, 4'b0000);
`endif

    // Request together with music: effect first, then music resumes; mute stops it.
    goTo(c0 + 20); c0 = cyc;
    setEffect(1, 32'd4, 32'd2);
    music_valid = 1'b1;
    music_half_period = 32'd10;
    applyStimulus(c0, 4'b0010);
    expectAck(c0 + 2, 4'b0010, 2'd1);
    expectSample(c0 + 2,  POS,  1'b1, 2'd1);
    expectSample(c0 + 3,  POS,  1'b0, 2'd0);
    expectSample(c0 + 4,  POS,  1'b0, 2'd0);
    expectSample(c0 + 13, POS,  1'b0, 2'd0);
    expectSample(c0 + 14, NEG,  1'b0, 2'd0);
    expectSample(c0 + 21, ZERO, 1'b0, 2'd0);
    expectSample(c0 + 23, ZERO, 1'b0, 2'd0);
    applyStimulus(c0 + 3, 4'b0000);
    goTo(c0 + 20);
    mute = 1'b1;
    goTo(c0 + 21);
    mute = 1'b0;
    music_valid = 1'b0;

    // Asynchronous reset mid-effect: outputs clear at once, no ack.
    goTo(c0 + 26); c0 = cyc;
    setEffect(2, 32'd3, 32'd50);
    applyStimulus(c0, 4'b0100);
    expectSample(c0 + 5,  ZERO, 1'b0, 2'd0);
    expectSample(c0 + 16, ZERO, 1'b0, 2'd0);
    goTo(c0 + 3);
    checkOutput("pre_reset_busy", 32'(busy), 32'd1);
    goTo(c0 + 5);
    reset_n = 1'b0;
    #1;
    checkOutput("async_reset_busy", 32'(busy), ZERO);
    checkOutput("async_reset_ack", {28'b0, ack}, ZERO);
    checkOutput("async_reset_grant_id", {30'b0, grant_id}, ZERO);
    checkOutput("async_reset_left", left_channel_audio_out, ZERO);
    applyStimulus(c0 + 6, 4'b0000);
    for (int c = c0 + 6; c < c0 + 14; c++) begin
      goTo(c);
      audio_out_allowed = (c % 2 == 1);
    end
    goTo(c0 + 14);
    audio_out_allowed = 1'b1;
    reset_n = 1'b1;

    goTo(c0 + 20);
    checkOutput("ack_queue_drained", 32'(ackQ.size()), ZERO);
    checkOutput("sample_queue_drained", 32'(sampleQ.size()), ZERO);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
